// File: rtl/cpu_pkg.sv
// cpu_pkg: types and constants shared by the register-file write path.
//   REG_AW   - register address width (32 architectural registers)
//   XLEN     - datapath width
//   NUM_REGS - number of architectural registers
//   wr_req_t - one pending register write {rd, data}
//   wr_src_e - origin of the write currently on the register file port
package cpu_pkg;

  localparam int REG_AW   = 5;
  localparam int XLEN     = 32;
  localparam int NUM_REGS = 1 << REG_AW;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wr_req_t;

  typedef enum logic {
    SRC_WB = 1'b0,
    SRC_MD = 1'b1
  } wr_src_e;

endpackage

// File: rtl/regwrite_arbiter_if.sv
// regwrite_arbiter_if: every non-clock signal of the register-file write arbiter.
//   writeback : wb_en, wb_rd, wb_data
//   mul/div   : md_valid, md_ready, md_rd, md_data
//   issue     : iss_valid, iss_rd
//   decode    : rA, rB, rD lookups -> pend_a, pend_b, pend_d
//   control   : pipe_hold
//   regfile   : wE, rW, busW
// The slave modport is the arbiter; the master modport is its surroundings.
interface regwrite_arbiter_if;
  import cpu_pkg::*;

  logic              wb_en;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;

  logic              md_valid;
  logic              md_ready;
  logic [REG_AW-1:0] md_rd;
  logic [XLEN-1:0]   md_data;

  logic              iss_valid;
  logic [REG_AW-1:0] iss_rd;

  logic [REG_AW-1:0] rA;
  logic [REG_AW-1:0] rB;
  logic [REG_AW-1:0] rD;
  logic              pend_a;
  logic              pend_b;
  logic              pend_d;

  logic              pipe_hold;

  logic              wE;
  logic [REG_AW-1:0] rW;
  logic [XLEN-1:0]   busW;

  modport slave (
    input  wb_en, wb_rd, wb_data,
    input  md_valid, md_rd, md_data,
    output md_ready,
    input  iss_valid, iss_rd,
    input  rA, rB, rD,
    output pend_a, pend_b, pend_d,
    output pipe_hold,
    output wE, rW, busW
  );

  modport master (
    output wb_en, wb_rd, wb_data,
    output md_valid, md_rd, md_data,
    input  md_ready,
    output iss_valid, iss_rd,
    output rA, rB, rD,
    input  pend_a, pend_b, pend_d,
    input  pipe_hold,
    input  wE, rW, busW
  );

endinterface

// File: rtl/wb_fifo2.sv
// wb_fifo2: two-entry FIFO buffering mul/div results for the write port.
//   clk, rst_n   - clock, asynchronous active-low reset
//   push_i       - store push_data_i (ignored when full unless popping)
//   push_data_i  - entry to store
//   pop_i        - consume head_o
//   head_o       - oldest entry; when empty it shows push_data_i so that a
//                  same-cycle push+pop flows straight through
//   full_o       - both entries occupied
//   empty_o      - no entries stored
module wb_fifo2
  import cpu_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push_i,
  input  wr_req_t push_data_i,
  input  logic    pop_i,
  output wr_req_t head_o,
  output logic    full_o,
  output logic    empty_o
);

  wr_req_t    mem_q [2];
  wr_req_t    mem_d [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q, count_d;
  logic       flow_through;
  logic       do_push;
  logic       do_pop;

  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'd2);

  // Push and pop on an empty FIFO hand the entry straight to the reader and
  // leave the storage untouched; a push while full is only taken alongside a pop.
  assign flow_through = empty_o && push_i && pop_i;
  assign do_push      = push_i && (!full_o || pop_i) && !flow_through;
  assign do_pop       = pop_i && !empty_o;
  assign head_o       = empty_o ? push_data_i : mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/regwrite_arbiter.sv
// regwrite_arbiter: merges pipeline writeback and buffered mul/div results onto
// the single register-file write port, and tracks which registers still await
// a mul/div result.
//   STARVE_LIMIT - cycles the buffered head may lose arbitration before a
//                  pipeline hold is forced (must be >= 2)
//   clk, rst_n   - clock, asynchronous active-low reset
//   bus          - slave side of regwrite_arbiter_if (writeback, mul/div
//                  handshake, issue, decode lookups, pipe_hold, wE/rW/busW)
module regwrite_arbiter
  import cpu_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  regwrite_arbiter_if.slave bus
);

  localparam int               CNT_W   = (STARVE_LIMIT > 2) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT - 1);

  wr_req_t md_req;
  wr_req_t wb_req;
  wr_req_t fifo_head;
  wr_req_t sel_req;
  wr_src_e sel_src;
  logic    sel_valid;
  logic    fifo_full;
  logic    fifo_empty;
  logic    fifo_pop;
  logic    md_push;

  logic              wE_q, wE_d;
  logic [REG_AW-1:0] rW_q, rW_d;
  logic [XLEN-1:0]   busW_q, busW_d;
  wr_src_e           src_q, src_d;
  logic              pipe_hold_q, pipe_hold_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_REGS-1:0] sb_q, sb_d;

  assign md_req = '{rd: bus.md_rd, data: bus.md_data};
  assign wb_req = '{rd: bus.wb_rd, data: bus.wb_data};

  assign bus.md_ready = !fifo_full;
  assign md_push      = bus.md_valid && !fifo_full;

  wb_fifo2 u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (md_push),
    .push_data_i (md_req),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Write-port arbitration: a forced hold drains the head, otherwise the
  // pipeline wins, otherwise any available mul/div result (stored or arriving
  // this cycle into an empty FIFO) goes out.
  always_comb begin
    fifo_pop  = 1'b0;
    sel_valid = 1'b0;
    sel_req   = '0;
    sel_src   = SRC_WB;
    if (pipe_hold_q) begin
      fifo_pop  = !fifo_empty;
      sel_valid = !fifo_empty;
      sel_req   = fifo_head;
      sel_src   = SRC_MD;
    end else if (bus.wb_en) begin
      sel_valid = 1'b1;
      sel_req   = wb_req;
      sel_src   = SRC_WB;
    end else if (!fifo_empty || md_push) begin
      fifo_pop  = 1'b1;
      sel_valid = 1'b1;
      sel_req   = fifo_head;
      sel_src   = SRC_MD;
    end
  end

  // A write to r0 still consumes its slot but never reaches the register file.
  always_comb begin
    wE_d   = sel_valid && (sel_req.rd != '0);
    rW_d   = rW_q;
    busW_d = busW_q;
    src_d  = SRC_WB;
    if (wE_d) begin
      rW_d   = sel_req.rd;
      busW_d = sel_req.data;
      src_d  = sel_src;
    end
  end

  // Starvation: count cycles a stored head is passed over. The hold is
  // registered, so it lands the cycle after the count reaches its limit and
  // the pop it causes clears the count again.
  always_comb begin
    cnt_d = '0;
    if (!fifo_empty && !fifo_pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    pipe_hold_d = (cnt_d == CNT_MAX);
  end

  // Scoreboard: cleared by a committed mul/div write, set by issue; the set
  // is applied last so it wins on the same bit. r0 is never marked.
  always_comb begin
    sb_d = sb_q;
    if (wE_q && (src_q == SRC_MD)) begin
      sb_d[rW_q] = 1'b0;
    end
    if (bus.iss_valid && (bus.iss_rd != '0)) begin
      sb_d[bus.iss_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wE_q        <= 1'b0;
      rW_q        <= '0;
      busW_q      <= '0;
      src_q       <= SRC_WB;
      pipe_hold_q <= 1'b0;
      cnt_q       <= '0;
      sb_q        <= '0;
    end else begin
      wE_q        <= wE_d;
      rW_q        <= rW_d;
      busW_q      <= busW_d;
      src_q       <= src_d;
      pipe_hold_q <= pipe_hold_d;
      cnt_q       <= cnt_d;
      sb_q        <= sb_d;
    end
  end

  assign bus.wE        = wE_q;
  assign bus.rW        = rW_q;
  assign bus.busW      = busW_q;
  assign bus.pipe_hold = pipe_hold_q;

  // Lookups read the registered scoreboard directly; no same-cycle bypass.
  assign bus.pend_a = sb_q[bus.rA];
  assign bus.pend_b = sb_q[bus.rB];
  assign bus.pend_d = sb_q[bus.rD];

  // Writeback must present a bubble while the hold drains the FIFO head.
  a_no_wb_during_hold : assert property (
    @(posedge clk) disable iff (!rst_n) !(pipe_hold_q && bus.wb_en)
  );

endmodule

// File: tb/tb_regwrite_arbiter.sv
// tb_regwrite_arbiter: directed checks of the register-file write arbiter:
// reset, pipeline writes, mul/div path with scoreboard, contention with
// starvation hold, same-bit set/clear, r0 handling and mid-operation reset.
module tb_regwrite_arbiter;
  import cpu_pkg::*;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  regwrite_arbiter_if bus ();

  regwrite_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wb_en     = 1'b0;
    bus.wb_rd     = '0;
    bus.wb_data   = '0;
    bus.md_valid  = 1'b0;
    bus.md_rd     = '0;
    bus.md_data   = '0;
    bus.iss_valid = 1'b0;
    bus.iss_rd    = '0;
    bus.rA        = '0;
    bus.rB        = '0;
    bus.rD        = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.wb_en     = 1'($urandom);
      bus.wb_rd     = 5'($urandom);
      bus.wb_data   = $urandom;
      bus.md_valid  = 1'($urandom);
      bus.md_rd     = 5'($urandom);
      bus.md_data   = $urandom;
      bus.iss_valid = 1'($urandom);
      bus.iss_rd    = 5'($urandom);
      bus.rA        = 5'($urandom);
      bus.rB        = 5'($urandom);
      bus.rD        = 5'($urandom);
      step();
      tests_run++; if (bus.wE !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_wE: got %0b want 0", bus.wE); end
      tests_run++; if (bus.md_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_md_ready: got %0b want 1", bus.md_ready); end
      tests_run++; if ({bus.pend_a, bus.pend_b, bus.pend_d} !== 3'b000) begin tests_failed++; $display("[TB] FAIL reset_pend: got %03b want 000", {bus.pend_a, bus.pend_b, bus.pend_d}); end
    end
    idle_inputs();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      tests_run++; if (bus.wE !== 1'b0) begin tests_failed++; $display("[TB] FAIL release_wE: got %0b want 0", bus.wE); end
      tests_run++; if (bus.pipe_hold !== 1'b0) begin tests_failed++; $display("[TB] FAIL release_hold: got %0b want 0", bus.pipe_hold); end
    end
  endtask

  task automatic test_pipeline();
    idle_inputs();
    bus.wb_en = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'h0000_1234; bus.rA = 5'd5;
    step();
    tests_run++; if (bus.wE !== 1'b1) begin tests_failed++; $display("[TB] FAIL pipe_wE: got %0b want 1", bus.wE); end
    tests_run++; if (bus.rW !== 5'd5) begin tests_failed++; $display("[TB] FAIL pipe_rW: got %0d want 5", bus.rW); end
    tests_run++; if (bus.busW !== 32'h0000_1234) begin tests_failed++; $display("[TB] FAIL pipe_busW: got %h want 00001234", bus.busW); end
    tests_run++; if (bus.pend_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL pipe_no_pend: got %0b want 0", bus.pend_a); end
    bus.wb_rd = 5'd0; bus.wb_data = 32'hFFFF_FFFF;
    step();
    tests_run++; if (bus.wE !== 1'b0) begin tests_failed++; $display("[TB] FAIL pipe_r0_wE: got %0b want 0", bus.wE); end
    bus.wb_en = 1'b0;
    step();
  endtask

  task automatic test_md_scoreboard();
    idle_inputs();
    bus.rA = 5'd7; bus.rB = 5'd7; bus.rD = 5'd7;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    #1;
    tests_run++; if (bus.pend_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL md_no_bypass: got %0b want 0", bus.pend_a); end
    step();
    bus.iss_valid = 1'b0;
    tests_run++; if ({bus.pend_a, bus.pend_b, bus.pend_d} !== 3'b111) begin tests_failed++; $display("[TB] FAIL md_pend_set: got %03b want 111", {bus.pend_a, bus.pend_b, bus.pend_d}); end
    step();
    tests_run++; if (bus.pend_a !== 1'b1) begin tests_failed++; $display("[TB] FAIL md_pend_hold: got %0b want 1", bus.pend_a); end
    bus.md_valid = 1'b1; bus.md_rd = 5'd7; bus.md_data = 32'h0000_DEAD;
    #1;
    tests_run++; if (bus.md_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL md_ready_empty: got %0b want 1", bus.md_ready); end
    step();
    bus.md_valid = 1'b0;
    tests_run++; if (bus.wE !== 1'b1) begin tests_failed++; $display("[TB] FAIL md_wE: got %0b want 1", bus.wE); end
    tests_run++; if (bus.rW !== 5'd7) begin tests_failed++; $display("[TB] FAIL md_rW: got %0d want 7", bus.rW); end
    tests_run++; if (bus.busW !== 32'h0000_DEAD) begin tests_failed++; $display("[TB] FAIL md_busW: got %h want 0000dead", bus.busW); end
    tests_run++; if (bus.pend_a !== 1'b1) begin tests_failed++; $display("[TB] FAIL md_pend_at_write: got %0b want 1", bus.pend_a); end
    step();
    tests_run++; if (bus.pend_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL md_pend_clear: got %0b want 0", bus.pend_a); end
    tests_run++; if (bus.wE !== 1'b0) begin tests_failed++; $display("[TB] FAIL md_single_write: got %0b want 0", bus.wE); end
  endtask

  task automatic test_contention();
    idle_inputs();
    bus.wb_en = 1'b1; bus.wb_rd = 5'd20; bus.wb_data = 32'd1;
    bus.md_valid = 1'b1; bus.md_rd = 5'd10; bus.md_data = 32'h0000_A0A0;
    #1;
    tests_run++; if (bus.md_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL cont_ready_c0: got %0b want 1", bus.md_ready); end
    step();
    tests_run++; if ({bus.wE, bus.rW, bus.busW} !== {1'b1, 5'd20, 32'd1}) begin tests_failed++; $display("[TB] FAIL cont_wb_c1: got wE=%0b rW=%0d busW=%h want 1/20/00000001", bus.wE, bus.rW, bus.busW); end
    tests_run++; if (bus.md_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL cont_ready_c1: got %0b want 1", bus.md_ready); end
    bus.wb_data = 32'd2; bus.md_rd = 5'd11; bus.md_data = 32'h0000_B0B0;
    step();
    tests_run++; if (bus.md_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL cont_full_c2: got %0b want 0", bus.md_ready); end
    tests_run++; if (bus.busW !== 32'd2) begin tests_failed++; $display("[TB] FAIL cont_wb_c2: got %h want 00000002", bus.busW); end
    bus.wb_data = 32'd3; bus.md_rd = 5'd12; bus.md_data = 32'h0000_C0C0;
    step();
    tests_run++; if (bus.md_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL cont_full_c3: got %0b want 0", bus.md_ready); end
    tests_run++; if (bus.pipe_hold !== 1'b0) begin tests_failed++; $display("[TB] FAIL cont_hold_early: got %0b want 0", bus.pipe_hold); end
    bus.wb_data = 32'd4;
    step();
    tests_run++; if (bus.pipe_hold !== 1'b1) begin tests_failed++; $display("[TB] FAIL cont_hold_c4: got %0b want 1", bus.pipe_hold); end
    tests_run++; if ({bus.wE, bus.rW, bus.busW} !== {1'b1, 5'd20, 32'd4}) begin tests_failed++; $display("[TB] FAIL cont_wb_c4: got wE=%0b rW=%0d busW=%h want 1/20/00000004", bus.wE, bus.rW, bus.busW); end
    tests_run++; if (bus.md_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL cont_full_c4: got %0b want 0", bus.md_ready); end
    bus.wb_en = 1'b0;
    step();
    tests_run++; if ({bus.wE, bus.rW, bus.busW} !== {1'b1, 5'd10, 32'h0000_A0A0}) begin tests_failed++; $display("[TB] FAIL cont_head_c5: got wE=%0b rW=%0d busW=%h want 1/10/0000a0a0", bus.wE, bus.rW, bus.busW); end
    tests_run++; if (bus.pipe_hold !== 1'b0) begin tests_failed++; $display("[TB] FAIL cont_hold_one: got %0b want 0", bus.pipe_hold); end
    tests_run++; if (bus.md_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL cont_ready_c5: got %0b want 1", bus.md_ready); end
    step();
    bus.md_valid = 1'b0;
    tests_run++; if ({bus.wE, bus.rW, bus.busW} !== {1'b1, 5'd11, 32'h0000_B0B0}) begin tests_failed++; $display("[TB] FAIL cont_second_c6: got wE=%0b rW=%0d busW=%h want 1/11/0000b0b0", bus.wE, bus.rW, bus.busW); end
    step();
    tests_run++; if ({bus.wE, bus.rW, bus.busW} !== {1'b1, 5'd12, 32'h0000_C0C0}) begin tests_failed++; $display("[TB] FAIL cont_third_c7: got wE=%0b rW=%0d busW=%h want 1/12/0000c0c0", bus.wE, bus.rW, bus.busW); end
    step();
    tests_run++; if ({bus.wE, bus.md_ready} !== 2'b01) begin tests_failed++; $display("[TB] FAIL cont_drained_c8: got wE=%0b md_ready=%0b want 0/1", bus.wE, bus.md_ready); end
  endtask

  task automatic test_same_bit();
    idle_inputs();
    bus.rA = 5'd9; bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    step();
    bus.iss_valid = 1'b0;
    tests_run++; if (bus.pend_a !== 1'b1) begin tests_failed++; $display("[TB] FAIL same_set: got %0b want 1", bus.pend_a); end
    bus.md_valid = 1'b1; bus.md_rd = 5'd9; bus.md_data = 32'h0000_0099;
    step();
    bus.md_valid = 1'b0;
    tests_run++; if ({bus.wE, bus.rW} !== {1'b1, 5'd9}) begin tests_failed++; $display("[TB] FAIL same_commit: got wE=%0b rW=%0d want 1/9", bus.wE, bus.rW); end
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    step();
    bus.iss_valid = 1'b0;
    tests_run++; if (bus.pend_a !== 1'b1) begin tests_failed++; $display("[TB] FAIL same_set_wins: got %0b want 1", bus.pend_a); end
    bus.md_valid = 1'b1; bus.md_rd = 5'd9; bus.md_data = 32'h0000_0098;
    step();
    bus.md_valid = 1'b0;
    tests_run++; if ({bus.wE, bus.busW, bus.pend_a} !== {1'b1, 32'h0000_0098, 1'b1}) begin tests_failed++; $display("[TB] FAIL same_second_commit: got wE=%0b busW=%h pend_a=%0b want 1/00000098/1", bus.wE, bus.busW, bus.pend_a); end
    step();
    tests_run++; if (bus.pend_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL same_final_clear: got %0b want 0", bus.pend_a); end
  endtask

  task automatic test_reg0();
    idle_inputs();
    bus.rD = 5'd0; bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
    bus.md_valid = 1'b1; bus.md_rd = 5'd0; bus.md_data = 32'h5555_5555;
    step();
    bus.iss_valid = 1'b0; bus.md_valid = 1'b0;
    tests_run++; if (bus.wE !== 1'b0) begin tests_failed++; $display("[TB] FAIL r0_md_wE: got %0b want 0", bus.wE); end
    tests_run++; if (bus.pend_d !== 1'b0) begin tests_failed++; $display("[TB] FAIL r0_never_pending: got %0b want 0", bus.pend_d); end
    step();
    tests_run++; if ({bus.wE, bus.md_ready} !== 2'b01) begin tests_failed++; $display("[TB] FAIL r0_slot_consumed: got wE=%0b md_ready=%0b want 0/1", bus.wE, bus.md_ready); end
  endtask

  task automatic test_mid_reset();
    idle_inputs();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
    step();
    bus.iss_rd = 5'd4;
    step();
    bus.iss_valid = 1'b0;
    bus.rA = 5'd3; bus.rB = 5'd4;
    bus.wb_en = 1'b1; bus.wb_rd = 5'd21; bus.wb_data = 32'h77;
    bus.md_valid = 1'b1; bus.md_rd = 5'd3; bus.md_data = 32'h333;
    step();
    bus.md_rd = 5'd4; bus.md_data = 32'h444;
    step();
    bus.md_valid = 1'b0;
    tests_run++; if ({bus.md_ready, bus.pend_a, bus.pend_b} !== 3'b011) begin tests_failed++; $display("[TB] FAIL mrst_before: got ready=%0b pend_a=%0b pend_b=%0b want 0/1/1", bus.md_ready, bus.pend_a, bus.pend_b); end
    rst_n = 1'b0; bus.wb_en = 1'b0;
    #1;
    tests_run++; if (bus.md_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL mrst_ready: got %0b want 1", bus.md_ready); end
    tests_run++; if ({bus.pend_a, bus.pend_b, bus.wE} !== 3'b000) begin tests_failed++; $display("[TB] FAIL mrst_clear: got pend_a=%0b pend_b=%0b wE=%0b want 0/0/0", bus.pend_a, bus.pend_b, bus.wE); end
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++; if ({bus.wE, bus.pipe_hold, bus.md_ready} !== 3'b001) begin tests_failed++; $display("[TB] FAIL mrst_after_%0d: got wE=%0b hold=%0b ready=%0b want 0/0/1", i, bus.wE, bus.pipe_hold, bus.md_ready); end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    idle_inputs();
    test_reset();
    test_pipeline();
    test_md_scoreboard();
    test_contention();
    test_same_bit();
    test_reg0();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] simulation timed out");
  end

endmodule
